// File: rtl/alu_sequencer.sv
// Execute-stage controller for the ALU: accepts one instruction per handshake,
// walks IDLE -> EXEC -> WB, captures result/flags and emits a one-cycle writeback.
module alu_sequencer #(
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_issue_valid,
  output logic          o_issue_ready,
  input  logic [4:0]    i_issue_op,
  input  logic [RW-1:0] i_issue_dst,
  output logic [1:0]    o_alu_stage,
  output logic [4:0]    o_alu_op,
  output logic          o_alu_ci,
  input  logic [DW-1:0] i_alu_out,
  input  logic          i_alu_co,
  input  logic          i_alu_equal,
  input  logic          i_alu_gt,
  input  logic          i_alu_lt,
  input  logic          i_alu_zero,
  output logic          o_wb_en,
  output logic [RW-1:0] o_wb_dst,
  output logic [DW-1:0] o_wb_data,
  output logic          o_flag_c,
  output logic          o_flag_z,
  output logic          o_flag_eq,
  output logic          o_flag_gt,
  output logic          o_flag_lt,
  output logic          o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00111, OP_ADDS = 5'b10110, OP_SUBS = 5'b10111;
  localparam logic [4:0] OP_RSC  = 5'b10010, OP_LSC  = 5'b10100, OP_LSR  = 5'b10001;
  localparam logic [4:0] OP_LSL  = 5'b10011, OP_ASR  = 5'b11000, OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_DEC  = 5'b00010, OP_XOR  = 5'b10000, OP_AND  = 5'b01111;
  localparam logic [4:0] OP_OR   = 5'b10101, OP_NOT  = 5'b11100, OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_CMPU = 5'b11011;

  function automatic logic f_uses_ci(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_ADDS) || (op == OP_SUBS) ||
           (op == OP_RSC) || (op == OP_LSC);
  endfunction

  function automatic logic f_writes_c(input logic [4:0] op);
    return f_uses_ci(op) || (op == OP_LSR) || (op == OP_LSL) || (op == OP_ASR);
  endfunction

  function automatic logic f_is_cmp(input logic [4:0] op);
    return (op == OP_CMP) || (op == OP_CMPU);
  endfunction

  function automatic logic f_is_legal(input logic [4:0] op);
    return f_writes_c(op) || f_is_cmp(op) || (op == OP_SUB) || (op == OP_DEC) ||
           (op == OP_XOR) || (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
  endfunction

  state_t          r_state, w_state_next;
  logic [4:0]      r_op, w_op_next;
  logic [RW-1:0]   r_dst, w_dst_next;
  logic [4:0]      r_alu_op, w_alu_op_next;
  logic            r_alu_ci, w_alu_ci_next;
  logic            r_wb_en, w_wb_en_next;
  logic [RW-1:0]   r_wb_dst, w_wb_dst_next;
  logic [DW-1:0]   r_wb_data, w_wb_data_next;
  logic            r_err, w_err_next;
  logic            r_flag_c, w_flag_c_next;
  logic            r_flag_z, w_flag_z_next;
  logic            r_flag_eq, w_flag_eq_next;
  logic            r_flag_gt, w_flag_gt_next;
  logic            r_flag_lt, w_flag_lt_next;
  logic            w_accept;

  assign w_accept = i_issue_valid && (r_state != S_EXEC);

  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_dst_next     = r_dst;
    w_alu_op_next  = r_alu_op;
    w_alu_ci_next  = r_alu_ci;
    w_wb_en_next   = 1'b0;
    w_wb_dst_next  = '0;
    w_wb_data_next = r_wb_data;
    w_err_next     = 1'b0;
    w_flag_c_next  = r_flag_c;
    w_flag_z_next  = r_flag_z;
    w_flag_eq_next = r_flag_eq;
    w_flag_gt_next = r_flag_gt;
    w_flag_lt_next = r_flag_lt;
    case (r_state)
      S_IDLE, S_WB: begin
        if (w_accept) begin
          // Flags are already final here, so carry-in for a back-to-back op is current.
          w_state_next  = S_EXEC;
          w_op_next     = i_issue_op;
          w_dst_next    = i_issue_dst;
          w_alu_op_next = i_issue_op;
          w_alu_ci_next = f_uses_ci(i_issue_op) & r_flag_c;
        end else begin
          w_state_next  = S_IDLE;
          w_alu_op_next = 5'b00000;
          w_alu_ci_next = 1'b0;
        end
      end
      S_EXEC: begin
        w_state_next   = S_WB;
        w_alu_op_next  = 5'b00000;
        w_alu_ci_next  = 1'b0;
        w_wb_data_next = i_alu_out;
        if (f_is_legal(r_op)) begin
          w_flag_z_next = i_alu_zero;
          if (f_writes_c(r_op)) w_flag_c_next = i_alu_co;
          if (f_is_cmp(r_op)) begin
            w_flag_eq_next = i_alu_equal;
            w_flag_gt_next = i_alu_gt;
            w_flag_lt_next = i_alu_lt;
          end else begin
            w_wb_en_next  = 1'b1;
            w_wb_dst_next = r_dst;
          end
        end else begin
          w_err_next = 1'b1;
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_alu_op_next = 5'b00000;
        w_alu_ci_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_op      <= 5'b00000;
      r_dst     <= '0;
      r_alu_op  <= 5'b00000;
      r_alu_ci  <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
      r_flag_c  <= 1'b0;
      r_flag_z  <= 1'b0;
      r_flag_eq <= 1'b0;
      r_flag_gt <= 1'b0;
      r_flag_lt <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_dst     <= w_dst_next;
      r_alu_op  <= w_alu_op_next;
      r_alu_ci  <= w_alu_ci_next;
      r_wb_en   <= w_wb_en_next;
      r_wb_dst  <= w_wb_dst_next;
      r_wb_data <= w_wb_data_next;
      r_err     <= w_err_next;
      r_flag_c  <= w_flag_c_next;
      r_flag_z  <= w_flag_z_next;
      r_flag_eq <= w_flag_eq_next;
      r_flag_gt <= w_flag_gt_next;
      r_flag_lt <= w_flag_lt_next;
    end
  end

  assign o_issue_ready = (r_state != S_EXEC);
  assign o_alu_stage   = r_state;
  assign o_alu_op      = r_alu_op;
  assign o_alu_ci      = r_alu_ci;
  assign o_wb_en       = r_wb_en;
  assign o_wb_dst      = r_wb_dst;
  assign o_wb_data     = r_wb_data;
  assign o_err         = r_err;
  assign o_flag_c      = r_flag_c;
  assign o_flag_z      = r_flag_z;
  assign o_flag_eq     = r_flag_eq;
  assign o_flag_gt     = r_flag_gt;
  assign o_flag_lt     = r_flag_lt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays the ALU by driving
// hand-computed result/flag values for each instruction.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [4:0]    issue_op;
  logic [RW-1:0] issue_dst;
  logic [1:0]    alu_stage;
  logic [4:0]    alu_op;
  logic          alu_ci;
  logic [DW-1:0] alu_out;
  logic          alu_co, alu_equal, alu_gt, alu_lt, alu_zero;
  logic          wb_en;
  logic [RW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic          flag_c, flag_z, flag_eq, flag_gt, flag_lt;
  logic          err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DW(DW), .RW(RW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
    .i_issue_op(issue_op), .i_issue_dst(issue_dst),
    .o_alu_stage(alu_stage), .o_alu_op(alu_op), .o_alu_ci(alu_ci),
    .i_alu_out(alu_out), .i_alu_co(alu_co), .i_alu_equal(alu_equal),
    .i_alu_gt(alu_gt), .i_alu_lt(alu_lt), .i_alu_zero(alu_zero),
    .o_wb_en(wb_en), .o_wb_dst(wb_dst), .o_wb_data(wb_data),
    .o_flag_c(flag_c), .o_flag_z(flag_z), .o_flag_eq(flag_eq),
    .o_flag_gt(flag_gt), .o_flag_lt(flag_lt), .o_err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one posedge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [7:0] o, input logic co, input logic eq,
                         input logic gt, input logic lt, input logic z);
    alu_out = o; alu_co = co; alu_equal = eq; alu_gt = gt; alu_lt = lt; alu_zero = z;
  endtask

  localparam logic [4:0] ADD = 5'b00111, XOR = 5'b10000, SUB = 5'b01110;
  localparam logic [4:0] CMP = 5'b00101, CMPU = 5'b11011, BAD = 5'b11111;

  logic [4:0] stream_ops  [3];
  logic [7:0] stream_data [3];

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_op = 5'b0; issue_dst = '0;
    set_alu(8'h00, 0, 0, 0, 0, 0);
    step(); step();
    check("rst_stage", 32'(alu_stage), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_flag_c", 32'(flag_c), 32'h0);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(issue_ready), 32'h1);

    // ADD 0x7F + 0x01 with carry clear
    set_alu(8'h80, 0, 0, 0, 0, 0);
    issue_valid = 1'b1; issue_op = ADD; issue_dst = 3'd3;
    step();
    issue_valid = 1'b0;
    check("add1_stage_exec", 32'(alu_stage), 32'h1);
    check("add1_alu_op", 32'(alu_op), 32'(ADD));
    check("add1_ci", 32'(alu_ci), 32'h0);
    check("add1_ready_exec", 32'(issue_ready), 32'h0);
    step();
    check("add1_stage_wb", 32'(alu_stage), 32'h2);
    check("add1_wb_en", 32'(wb_en), 32'h1);
    check("add1_wb_dst", 32'(wb_dst), 32'h3);
    check("add1_wb_data", 32'(wb_data), 32'h80);
    check("add1_flag_c", 32'(flag_c), 32'h0);
    check("add1_flag_z", 32'(flag_z), 32'h0);
    step();
    check("add1_idle", 32'(alu_stage), 32'h0);
    check("add1_wb_en_off", 32'(wb_en), 32'h0);

    // ADD 0xFF + 0x01 -> 0x00, carry and zero set
    set_alu(8'h00, 1, 0, 0, 0, 1);
    issue_valid = 1'b1; issue_op = ADD; issue_dst = 3'd5;
    step();
    issue_valid = 1'b0;
    step();
    check("add2_wb_data", 32'(wb_data), 32'h00);
    check("add2_flag_c", 32'(flag_c), 32'h1);
    check("add2_flag_z", 32'(flag_z), 32'h1);
    // ADD 0+0 accepted in WB: carry-in comes from flag_c
    set_alu(8'h01, 0, 0, 0, 0, 0);
    issue_valid = 1'b1; issue_op = ADD; issue_dst = 3'd6;
    step();
    issue_valid = 1'b0;
    check("add3_stage_exec", 32'(alu_stage), 32'h1);
    check("add3_ci", 32'(alu_ci), 32'h1);
    step();
    check("add3_wb_data", 32'(wb_data), 32'h01);
    check("add3_wb_dst", 32'(wb_dst), 32'h6);
    check("add3_flag_c", 32'(flag_c), 32'h0);
    step();

    // CMP 0x80 vs 0x01 (signed: less); co driven high must not reach flag_c
    set_alu(8'h7F, 1, 0, 0, 1, 0);
    issue_valid = 1'b1; issue_op = CMP;
    step();
    issue_valid = 1'b0;
    step();
    check("cmp_wb_en", 32'(wb_en), 32'h0);
    check("cmp_lt", 32'(flag_lt), 32'h1);
    check("cmp_gt", 32'(flag_gt), 32'h0);
    check("cmp_eq", 32'(flag_eq), 32'h0);
    check("cmp_flag_c", 32'(flag_c), 32'h0);
    step();
    // CMPU same operands (unsigned: greater)
    set_alu(8'h7F, 1, 0, 1, 0, 0);
    issue_valid = 1'b1; issue_op = CMPU;
    step();
    issue_valid = 1'b0;
    step();
    check("cmpu_wb_en", 32'(wb_en), 32'h0);
    check("cmpu_gt", 32'(flag_gt), 32'h1);
    check("cmpu_lt", 32'(flag_lt), 32'h0);
    step();

    // Continuous issue: ADD, XOR, SUB back to back; SUB result zero
    stream_ops[0] = ADD;  stream_data[0] = 8'h11;
    stream_ops[1] = XOR;  stream_data[1] = 8'h22;
    stream_ops[2] = SUB;  stream_data[2] = 8'h00;
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_op = stream_ops[i]; issue_dst = 3'(i + 1);
      set_alu(stream_data[i], 0, 0, 0, 0, (stream_data[i] == 8'h00));
      step();
      check($sformatf("stream%0d_stage_exec", i), 32'(alu_stage), 32'h1);
      check($sformatf("stream%0d_alu_op", i), 32'(alu_op), 32'(stream_ops[i]));
      if (i == 2) issue_valid = 1'b0;
      step();
      check($sformatf("stream%0d_stage_wb", i), 32'(alu_stage), 32'h2);
      check($sformatf("stream%0d_wb_en", i), 32'(wb_en), 32'h1);
      check($sformatf("stream%0d_wb_data", i), 32'(wb_data), 32'(stream_data[i]));
    end
    check("stream_flag_z", 32'(flag_z), 32'h1);
    step();

    // Reset in the middle of EXEC; simultaneous valid must be ignored
    set_alu(8'h30, 0, 0, 0, 0, 0);
    issue_valid = 1'b1; issue_op = ADD; issue_dst = 3'd7;
    step();
    check("rstmid_stage_exec", 32'(alu_stage), 32'h1);
    reset = 1'b1;
    step();
    check("rstmid_stage", 32'(alu_stage), 32'h0);
    check("rstmid_alu_op", 32'(alu_op), 32'h0);
    check("rstmid_wb_en", 32'(wb_en), 32'h0);
    check("rstmid_wb_data", 32'(wb_data), 32'h0);
    check("rstmid_flags", 32'({flag_c, flag_z, flag_eq, flag_gt, flag_lt}), 32'h0);
    reset = 1'b0; issue_valid = 1'b0;
    step();
    check("rstmid_ready", 32'(issue_ready), 32'h1);
    step();
    check("rstmid_no_wb", 32'(wb_en), 32'h0);

    // Preset flag_c via ADD with carry out, then issue an illegal opcode
    set_alu(8'h00, 1, 0, 0, 0, 0);
    issue_valid = 1'b1; issue_op = ADD; issue_dst = 3'd1;
    step();
    issue_valid = 1'b0;
    step();
    check("pre_flag_c", 32'(flag_c), 32'h1);
    step();
    set_alu(8'hAA, 0, 1, 1, 1, 1);
    issue_valid = 1'b1; issue_op = BAD;
    step();
    issue_valid = 1'b0;
    check("bad_ci", 32'(alu_ci), 32'h0);
    check("bad_err_exec", 32'(err), 32'h0);
    step();
    check("bad_stage_wb", 32'(alu_stage), 32'h2);
    check("bad_err", 32'(err), 32'h1);
    check("bad_wb_en", 32'(wb_en), 32'h0);
    check("bad_flag_c", 32'(flag_c), 32'h1);
    check("bad_flag_z", 32'(flag_z), 32'h0);
    check("bad_flag_cmp", 32'({flag_eq, flag_gt, flag_lt}), 32'h0);
    step();
    check("bad_err_off", 32'(err), 32'h0);
    check("bad_idle", 32'(alu_stage), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
